// File: rtl/regfile_scoreboard_pkg.sv
// regfile_pkg: shared defaults for the register file / scoreboard block.
//   DEF_WIDTH  - default register word width
//   DEF_NREGS  - default register count
//   DEF_AW     - default register index width
//   idx_width  - index width for a given register count (never below 1)
package regfile_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_NREGS = 8;

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_AW = idx_width(DEF_NREGS);
endpackage

// File: rtl/regfile_scoreboard_onehot_decoder.sv
// onehot_decoder: binary register index to one-hot enable vector.
//   i_idx    - binary index
//   i_en     - enable; with i_en low the vector is all zero
//   o_onehot - one bit per register, set for the addressed register
//   o_oor    - i_en high with an index that names no register
module onehot_decoder
   import regfile_pkg::*;
#(
   parameter int AW    = DEF_AW,
   parameter int NREGS = DEF_NREGS
) (
   input  logic [AW-1:0]    i_idx,
   input  logic             i_en,
   output logic [NREGS-1:0] o_onehot,
   output logic             o_oor
);

   for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
      assign o_onehot[gi] = i_en && (i_idx == AW'(gi));
   end

   // Only a non power-of-two register count leaves unused index codes.
   if (NREGS < (1 << AW)) begin : g_oor
      assign o_oor = i_en && ({1'b0, i_idx} >= (AW+1)'(NREGS));
   end else begin : g_no_oor
      assign o_oor = 1'b0;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: two-read/one-write register file with a per-register
// pending (scoreboard) bit.
//   clk, reset            - clock, synchronous active-high reset
//   data_in/writenum/write - write port
//   readnum_a/readnum_b    - combinational read indices
//   data_out_a/data_out_b  - read data (0 for out-of-range index)
//   busy_a/busy_b          - pending bit of the addressed register
//   reserve/reservenum     - mark a register pending (producer issued)
//   reserve_err            - registered pulse for an illegal write/reserve
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NREGS  = DEF_NREGS,
   parameter bit BYPASS = 1'b1,
   parameter int AW     = idx_width(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AW-1:0]    writenum,
   input  logic             write,
   input  logic [AW-1:0]    readnum_a,
   input  logic [AW-1:0]    readnum_b,
   output logic [WIDTH-1:0] data_out_a,
   output logic [WIDTH-1:0] data_out_b,
   output logic             busy_a,
   output logic             busy_b,
   input  logic             reserve,
   input  logic [AW-1:0]    reservenum,
   output logic             reserve_err
);

   logic [WIDTH-1:0] r_regs [NREGS];
   logic [NREGS-1:0] r_pend;
   logic             r_err;

   logic [NREGS-1:0] w_wr_oh, w_rs_oh, w_rs_set;
   logic             w_wr_oor, w_rs_oor, w_rs_busy, w_err;
   logic [WIDTH-1:0] w_data_a, w_data_b;
   logic             w_busy_a, w_busy_b;

   onehot_decoder #(.AW(AW), .NREGS(NREGS)) u_wr_dec (
      .i_idx    (writenum),
      .i_en     (write),
      .o_onehot (w_wr_oh),
      .o_oor    (w_wr_oor)
   );

   onehot_decoder #(.AW(AW), .NREGS(NREGS)) u_rs_dec (
      .i_idx    (reservenum),
      .i_en     (reserve),
      .o_onehot (w_rs_oh),
      .o_oor    (w_rs_oor)
   );

   // Reserving a pending register is an error unless the same cycle's
   // write retires the old producer: then the new producer simply takes over.
   assign w_rs_busy = |(w_rs_oh & r_pend & ~w_wr_oh);
   assign w_rs_set  = w_rs_busy ? '0 : w_rs_oh;
   assign w_err     = w_wr_oor | w_rs_oor | w_rs_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_pend <= '0;
         r_err  <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (w_wr_oh[i]) r_regs[i] <= data_in;
         end
         // Set after clear so a same-index reserve leaves the bit set.
         r_pend <= (r_pend & ~w_wr_oh) | w_rs_set;
         r_err  <= w_err;
      end
   end

   always_comb begin
      w_data_a = '0;
      w_busy_a = 1'b0;
      w_data_b = '0;
      w_busy_b = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         if (readnum_a == AW'(i)) begin
            w_data_a = r_regs[i];
            w_busy_a = r_pend[i];
         end
         if (readnum_b == AW'(i)) begin
            w_data_b = r_regs[i];
            w_busy_b = r_pend[i];
         end
      end
      if (BYPASS && write && !w_wr_oor) begin
         if (writenum == readnum_a) begin
            w_data_a = data_in;
            w_busy_a = 1'b0;
         end
         if (writenum == readnum_b) begin
            w_data_b = data_in;
            w_busy_b = 1'b0;
         end
      end
   end

   assign data_out_a  = w_data_a;
   assign data_out_b  = w_data_b;
   assign busy_a      = w_busy_a;
   assign busy_b      = w_busy_b;
   assign reserve_err = r_err;

endmodule
